// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the four-way stream demultiplexer
package mux_pkg;

  localparam int NUM_OUT = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid/ready and a delivery counter
module demux_slot
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic             slot_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (pop && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (state_q == FULL);
    pop        = out_valid && out_ready;
    // Slot can accept when empty or when the held word leaves this same cycle.
    slot_ready = !out_valid || out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= in_data;
    end
  end

  // Clear wins over a concurrent pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign dout = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/stream_demux4.sv
// rtl/stream_demux4.sv - four-way registered stream demultiplexer with per-output counters
module stream_demux4
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [WIDTH-1:0] dout4,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] cnt4
);

  logic [NUM_OUT-1:0] slot_ready;
  logic [NUM_OUT-1:0] load;
  logic [WIDTH-1:0]   dout_a [NUM_OUT];
  logic [CNT_W-1:0]   cnt_a  [NUM_OUT];
  logic               push;
  sel_t               sel;

  assign sel = in_sel;

  // Readiness depends only on the addressed slot, so stalled slots never block others.
  assign in_ready = slot_ready[sel];
  assign push     = in_valid && in_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign load[k] = push && (sel == sel_t'(k));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[k]),
      .in_data    (in_data),
      .out_ready  (out_ready[k]),
      .cnt_clr    (cnt_clr),
      .slot_ready (slot_ready[k]),
      .out_valid  (out_valid[k]),
      .dout       (dout_a[k]),
      .cnt        (cnt_a[k])
    );
  end

  assign dout1 = dout_a[0];
  assign dout2 = dout_a[1];
  assign dout3 = dout_a[2];
  assign dout4 = dout_a[3];
  assign cnt1  = cnt_a[0];
  assign cnt2  = cnt_a[1];
  assign cnt3  = cnt_a[2];
  assign cnt4  = cnt_a[3];

endmodule

// File: tb/tb_stream_demux4.sv
// tb/tb_stream_demux4.sv - self-checking bench for stream_demux4
module tb_stream_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] dout1, dout2, dout3, dout4;
  logic       cnt_clr;
  logic [7:0] cnt1, cnt2, cnt3, cnt4;

  int total = 0;
  int bad   = 0;

  stream_demux4 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .dout4     (dout4),
    .cnt_clr   (cnt_clr),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .cnt4      (cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: each output is a mailbox holding at most one word, plus a pop tally.
  logic [3:0] mv;
  logic [7:0] md [4];
  logic [7:0] mc [4];
  logic       m_ready;

  assign m_ready = !mv[in_sel] || out_ready[in_sel];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 4'b0;
      for (int k = 0; k < 4; k++) begin
        md[k] <= 8'h00;
        mc[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr) mc[k] <= 8'h00;
        else if (mv[k] && out_ready[k]) mc[k] <= mc[k] + 8'd1;
        if (in_valid && m_ready && in_sel == k[1:0]) begin
          mv[k] <= 1'b1;
          md[k] <= in_data;
        end else if (mv[k] && out_ready[k]) begin
          mv[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    check("out_valid", {28'd0, out_valid}, {28'd0, mv});
    check("dout", {dout4, dout3, dout2, dout1}, {md[3], md[2], md[1], md[0]});
    check("cnt", {cnt4, cnt3, cnt2, cnt1}, {mc[3], mc[2], mc[1], mc[0]});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic stalled;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'b00;
    out_ready = 4'b0000;
    cnt_clr   = 1'b0;

    #3;
    check("rst_out_valid", {28'd0, out_valid}, 32'h0);
    check("rst_cnt", {cnt4, cnt3, cnt2, cnt1}, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'h1);
    step();
    step();
    rst_n = 1'b1;

    push(2'b10, 8'hA5);
    check("first_valid", {28'd0, out_valid}, 32'h4);
    check("first_dout3", {24'd0, dout3}, 32'hA5);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;

    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    out_ready = 4'b0010;
    in_sel    = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      check("stream_ready", {31'd0, in_ready}, 32'h1);
      step();
      check("stream_dout2", {24'd0, dout2}, i);
    end
    in_valid = 1'b0;
    step();
    check("stream_cnt2", {24'd0, cnt2}, 32'd16);

    out_ready = 4'b0000;
    push(2'b00, 8'h11);
    in_valid = 1'b1;
    in_sel   = 2'b00;
    in_data  = 8'h55;
    #1;
    check("stall_ready", {31'd0, in_ready}, 32'h0);
    in_valid = 1'b0;
    push(2'b11, 8'h44);
    check("iso_dout4", {24'd0, dout4}, 32'h44);
    check("iso_dout1", {24'd0, dout1}, 32'h11);
    check("iso_valid", {28'd0, out_valid}, 32'h9);

    out_ready = 4'b1000;
    push(2'b11, 8'h22);
    check("swap1_dout4", {24'd0, dout4}, 32'h22);
    check("swap1_cnt4", {24'd0, cnt4}, 32'd1);
    push(2'b11, 8'h33);
    check("swap2_dout4", {24'd0, dout4}, 32'h33);
    check("swap2_valid", {31'd0, out_valid[3]}, 32'h1);
    check("swap2_cnt4", {24'd0, cnt4}, 32'd2);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;

    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    out_ready = 4'b0001;
    in_sel    = 2'b00;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("wrap_cnt1_255", {24'd0, cnt1}, 32'd255);
    step();
    check("wrap_cnt1_0", {24'd0, cnt1}, 32'd0);
    push(2'b00, 8'h77);
    step();
    check("cnt1_one", {24'd0, cnt1}, 32'd1);
    push(2'b00, 8'h78);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_beats_pop", {24'd0, cnt1}, 32'd0);
    check("clr_popped", {28'd0, out_valid}, 32'h0);

    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) push(2'(k), 8'(8'hC0 + k));
    check("all_full", {28'd0, out_valid}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {28'd0, out_valid}, 32'h0);
    check("midrst_cnt", {cnt4, cnt3, cnt2, cnt1}, 32'h0);
    check("midrst_dout", {dout4, dout3, dout2, dout1}, 32'h0);
    step();
    rst_n = 1'b1;

    stalled = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      out_ready = 4'($urandom);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom);
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      stalled = in_valid && !in_ready;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
